// File: rtl/csa_stream_accumulator_pkg.sv
// Shared definitions for the carry-save stream accumulator: state encoding
// and elaboration-time geometry helpers.
package csa_stream_accumulator_pkg;

   localparam logic [1:0] ST_ACCUM   = 2'd0;
   localparam logic [1:0] ST_RESOLVE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   function automatic int calc_nchunk(input int acc_bits, input int cpa_chunk);
      return acc_bits / cpa_chunk;
   endfunction

   // Chunk index width; never narrower than one bit so a single-chunk build still has a counter.
   function automatic int calc_idx_w(input int nchunk);
      return (nchunk < 2) ? 1 : $clog2(nchunk);
   endfunction

   function automatic bit cfg_ok(input int in_bits, input int acc_bits, input int cpa_chunk);
      return (cpa_chunk > 0) && (acc_bits % cpa_chunk == 0) && (acc_bits >= in_bits);
   endfunction

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Operand stream in / result stream out for the carry-save accumulator.
interface csa_stream_accumulator_if #(
   parameter int IN_BITS  = 32,
   parameter int ACC_BITS = 72,
   parameter int CNT_BITS = 16
);
   logic                in_valid;
   logic                in_ready;
   logic [IN_BITS-1:0]  in_data;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [ACC_BITS-1:0] out_data;
   logic [CNT_BITS-1:0] out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/csa_stream_accumulator_csa_3to2.sv
// Combinational 3:2 carry-save compressor; carry is pre-shifted into its
// weight position and the top carry bit is dropped (modulo 2^WIDTH).
module csa_3to2 #(
   parameter int WIDTH = 72
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);
   logic [WIDTH-1:0] maj;

   always_comb begin
      sum   = a ^ b ^ d;
      maj   = (a & b) | (a & d) | (b & d);
      carry = maj << 1;
   end
endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming accumulator: one 3:2 compression per beat, then a chunked
// carry-propagate resolve of sum+carry presented on a valid/ready output.
module csa_stream_accumulator
   import csa_stream_accumulator_pkg::*;
#(
   parameter int IN_BITS   = 32,
   parameter int ACC_BITS  = 72,
   parameter int CPA_CHUNK = 8,
   parameter int SIGNED_IN = 1,
   parameter int CNT_BITS  = 16
) (
   input  logic clk,
   input  logic rst_n,
   csa_stream_accumulator_if.slave bus
);
   // state      | meaning
   // ST_ACCUM   | accepting operands, compressing into s/c each beat
   // ST_RESOLVE | adding s+c one CPA_CHUNK slice per cycle, low slice first
   // ST_DONE    | result presented, waiting for out_ready

   localparam int NCHUNK = calc_nchunk(ACC_BITS, CPA_CHUNK);
   localparam int IDX_W  = calc_idx_w(NCHUNK);

   if (!cfg_ok(IN_BITS, ACC_BITS, CPA_CHUNK)) begin : g_cfg_err
      $error("csa_stream_accumulator: ACC_BITS must be >= IN_BITS and a multiple of CPA_CHUNK");
   end

   logic [1:0]          state_q, state_d;
   logic [ACC_BITS-1:0] s_q, s_d;
   logic [ACC_BITS-1:0] c_q, c_d;
   logic [ACC_BITS-1:0] result_q, result_d;
   logic [IDX_W-1:0]    k_q, k_d;
   logic                carry_q, carry_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   logic signed [IN_BITS-1:0] in_signed;
   logic [ACC_BITS-1:0]       x_ext;
   logic [ACC_BITS-1:0]       csa_sum, csa_carry;
   logic [CPA_CHUNK-1:0]      chunk_s, chunk_c;
   logic [CPA_CHUNK:0]        chunk_sum;
   logic                      in_ready_w;
   logic                      accept;
   logic                      last_chunk;

   always_comb begin
      in_signed = bus.in_data;
      x_ext     = (SIGNED_IN != 0) ? ACC_BITS'(in_signed) : ACC_BITS'(bus.in_data);
   end

   csa_3to2 #(.WIDTH(ACC_BITS)) u_csa (
      .a     (s_q),
      .b     (x_ext),
      .d     (c_q),
      .sum   (csa_sum),
      .carry (csa_carry)
   );

   always_comb begin
      in_ready_w = rst_n && (state_q == ST_ACCUM);
      accept     = bus.in_valid && in_ready_w;
      last_chunk = (k_q == IDX_W'(NCHUNK - 1));
   end

   // Chunk mux written as an unrolled compare so every select is constant.
   always_comb begin
      chunk_s = '0;
      chunk_c = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (k_q == IDX_W'(i)) begin
            chunk_s = s_q[i*CPA_CHUNK +: CPA_CHUNK];
            chunk_c = c_q[i*CPA_CHUNK +: CPA_CHUNK];
         end
      end
      chunk_sum = {1'b0, chunk_s} + {1'b0, chunk_c} + {{CPA_CHUNK{1'b0}}, carry_q};
   end

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      c_d      = c_q;
      result_d = result_q;
      k_d      = k_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;

      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               s_d   = csa_sum;
               c_d   = csa_carry;
               cnt_d = (cnt_q == {CNT_BITS{1'b1}}) ? cnt_q : cnt_q + 1'b1;
               if (bus.in_last) begin
                  state_d = ST_RESOLVE;
                  k_d     = '0;
                  carry_d = 1'b0;
               end
            end
         end

         ST_RESOLVE: begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (k_q == IDX_W'(i)) begin
                  result_d[i*CPA_CHUNK +: CPA_CHUNK] = chunk_sum[CPA_CHUNK-1:0];
               end
            end
            carry_d = chunk_sum[CPA_CHUNK];
            if (last_chunk) begin
               state_d = ST_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_ACCUM;
               s_d     = '0;
               c_d     = '0;
               cnt_d   = '0;
            end
         end

         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_ACCUM;
         s_q      <= '0;
         c_q      <= '0;
         result_q <= '0;
         k_q      <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         c_q      <= c_d;
         result_q <= result_d;
         k_q      <= k_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      bus.in_ready  = in_ready_w;
      bus.out_valid = (state_q == ST_DONE);
      bus.out_data  = result_q;
      bus.out_count = cnt_q;
   end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench driving a signed and an unsigned accumulator with the same
// stream; a reference model fills per-DUT scoreboards that monitors drain.
module tb_csa_stream_accumulator;
   localparam int IB = 8;
   localparam int AB = 16;
   localparam int CC = 4;
   localparam int CB = 8;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_last   = 1'b0;
   logic         out_ready = 1'b1;
   logic [IB-1:0] in_data  = '0;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   logic [AB-1:0] q_s_data[$];
   logic [AB-1:0] q_u_data[$];
   logic [CB-1:0] q_s_cnt[$];
   logic [CB-1:0] q_u_cnt[$];

   logic [AB-1:0] acc_s = '0;
   logic [AB-1:0] acc_u = '0;
   logic [CB-1:0] cnt_m = '0;

   always #5 clk = ~clk;

   csa_stream_accumulator_if #(.IN_BITS(IB), .ACC_BITS(AB), .CNT_BITS(CB)) if_s ();
   csa_stream_accumulator_if #(.IN_BITS(IB), .ACC_BITS(AB), .CNT_BITS(CB)) if_u ();

   assign if_s.in_valid  = in_valid;
   assign if_s.in_data   = in_data;
   assign if_s.in_last   = in_last;
   assign if_s.out_ready = out_ready;
   assign if_u.in_valid  = in_valid;
   assign if_u.in_data   = in_data;
   assign if_u.in_last   = in_last;
   assign if_u.out_ready = out_ready;

   csa_stream_accumulator #(
      .IN_BITS(IB), .ACC_BITS(AB), .CPA_CHUNK(CC), .SIGNED_IN(1), .CNT_BITS(CB)
   ) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_s)
   );

   csa_stream_accumulator #(
      .IN_BITS(IB), .ACC_BITS(AB), .CPA_CHUNK(CC), .SIGNED_IN(0), .CNT_BITS(CB)
   ) dut_u (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_u)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tot_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && if_s.out_valid && if_s.out_ready) begin
         if (q_s_data.size() == 0) begin
            chk("s_unexpected_result", {31'b0, if_s.out_valid}, 32'd0);
         end else begin
            chk("s_sb_out_data", 32'(if_s.out_data), 32'(q_s_data.pop_front()));
            chk("s_sb_out_count", 32'(if_s.out_count), 32'(q_s_cnt.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && if_u.out_valid && if_u.out_ready) begin
         if (q_u_data.size() == 0) begin
            chk("u_unexpected_result", {31'b0, if_u.out_valid}, 32'd0);
         end else begin
            chk("u_sb_out_data", 32'(if_u.out_data), 32'(q_u_data.pop_front()));
            chk("u_sb_out_count", 32'(if_u.out_count), 32'(q_u_cnt.pop_front()));
         end
      end
   end

   // Offers one beat until it is taken; the model follows only accepted beats.
   task automatic beat(input logic [IB-1:0] d, input logic last);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!if_s.in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         chk("beat_in_ready_wait", {31'b0, if_s.in_ready}, 32'd1);
      end else begin
         acc_s = acc_s + {{(AB-IB){d[IB-1]}}, d};
         acc_u = acc_u + {{(AB-IB){1'b0}}, d};
         cnt_m = (cnt_m == {CB{1'b1}}) ? cnt_m : cnt_m + 1'b1;
         if (last) begin
            q_s_data.push_back(acc_s);
            q_u_data.push_back(acc_u);
            q_s_cnt.push_back(cnt_m);
            q_u_cnt.push_back(cnt_m);
            acc_s = '0;
            acc_u = '0;
            cnt_m = '0;
         end
      end
      step();
      if (last) begin
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag, input logic [AB-1:0] exp_s,
                            input logic [AB-1:0] exp_u, input logic [CB-1:0] exp_cnt);
      int n;
      n = 0;
      while (!if_s.out_valid && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) begin
         chk({tag, "_timeout"}, {31'b0, if_s.out_valid}, 32'd1);
      end else begin
         chk({tag, "_s_data"}, 32'(if_s.out_data), 32'(exp_s));
         chk({tag, "_u_data"}, 32'(if_u.out_data), 32'(exp_u));
         chk({tag, "_s_count"}, 32'(if_s.out_count), 32'(exp_cnt));
         chk({tag, "_u_count"}, 32'(if_u.out_count), 32'(exp_cnt));
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      step();
      step();
      chk("rst_in_ready_s", {31'b0, if_s.in_ready}, 32'd0);
      chk("rst_in_ready_u", {31'b0, if_u.in_ready}, 32'd0);
      chk("rst_out_valid_s", {31'b0, if_s.out_valid}, 32'd0);
      chk("rst_out_data_s", 32'(if_s.out_data), 32'd0);
      chk("rst_out_count_s", 32'(if_s.out_count), 32'd0);
      chk("rst_out_data_u", 32'(if_u.out_data), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'b0, if_s.in_ready}, 32'd1);

      // three beats back-to-back: latency and single-cycle valid
      out_ready = 1'b1;
      beat(8'h05, 1'b0);
      beat(8'h07, 1'b0);
      beat(8'h03, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("lat_out_valid", {31'b0, if_s.out_valid}, {31'b0, (i == 4)});
         chk("lat_in_ready", {31'b0, if_s.in_ready}, {31'b0, (i == 5)});
         if (i == 4) begin
            chk("p1_s_data", 32'(if_s.out_data), 32'h000F);
            chk("p1_u_data", 32'(if_u.out_data), 32'h000F);
            chk("p1_count", 32'(if_s.out_count), 32'd3);
         end
      end

      // sign extension vs zero extension
      beat(8'hFF, 1'b0);
      beat(8'hFF, 1'b1);
      wait_done("ff2", 16'hFFFE, 16'h01FE, 8'd2);

      // 258 beats with bubbles that carry a stray in_last
      for (int i = 0; i < 258; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'hA5;
            in_last  = 1'b1;
            step();
         end
         beat(8'hFF, (i == 257));
      end
      wait_done("wrap", 16'hFEFE, 16'h00FE, 8'hFF);

      // backpressure in DONE while a new operand is offered
      out_ready = 1'b0;
      beat(8'h11, 1'b1);
      begin
         int n;
         n = 0;
         while (!if_s.out_valid && n < 40) begin
            step();
            n++;
         end
         if (n >= 40) chk("bp_timeout", {31'b0, if_s.out_valid}, 32'd1);
      end
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", {31'b0, if_s.out_valid}, 32'd1);
         chk("bp_in_ready", {31'b0, if_s.in_ready}, 32'd0);
         chk("bp_s_data", 32'(if_s.out_data), 32'h0011);
         chk("bp_u_data", 32'(if_u.out_data), 32'h0011);
         chk("bp_count", 32'(if_s.out_count), 32'd1);
         step();
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_released", {31'b0, if_s.out_valid}, 32'd0);
      beat(8'h02, 1'b1);
      wait_done("after_bp", 16'h0002, 16'h0002, 8'd1);

      // reset during RESOLVE discards the packet
      beat(8'h09, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", {31'b0, if_s.in_ready}, 32'd0);
      step();
      chk("rst_mid_out_valid", {31'b0, if_s.out_valid}, 32'd0);
      rst_n = 1'b1;
      q_s_data.delete();
      q_u_data.delete();
      q_s_cnt.delete();
      q_u_cnt.delete();
      for (int i = 0; i < 8; i++) begin
         step();
         chk("rst_abort_s", {31'b0, if_s.out_valid}, 32'd0);
         chk("rst_abort_u", {31'b0, if_u.out_valid}, 32'd0);
      end
      beat(8'h01, 1'b1);
      wait_done("after_rst", 16'h0001, 16'h0001, 8'd1);

      // single-beat packet
      beat(8'h80, 1'b1);
      wait_done("single", 16'hFF80, 16'h0080, 8'd1);

      step();
      step();
      chk("sb_empty_s", 32'(q_s_data.size()), 32'd0);
      chk("sb_empty_u", 32'(q_u_data.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Sequential successor to the combinational 3:2 carry-save stage used in the Booth radix-4 multiplier.
- Accepts a stream of operands, one per cycle, and accumulates them in redundant sum/carry form with a single 3:2 compression per beat, so there is no carry chain in the accumulate path.
- On the packet's last beat it resolves sum+carry with a multi-cycle chunked carry-propagate adder and presents the result on a valid/ready output.
- Used for partial-product and dot-product accumulation behind the Booth array.

Parameters:
- IN_BITS, 32, operand width.
- ACC_BITS, 72, accumulator/result width; must be >= IN_BITS and a multiple of CPA_CHUNK.
- CPA_CHUNK, 8, bits resolved per cycle by the final adder; NCHUNK = ACC_BITS/CPA_CHUNK.
- SIGNED_IN, 1, 1 = sign-extend operands to ACC_BITS, 0 = zero-extend.
- CNT_BITS, 16, width of the beat counter.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operand valid.
- in_ready, output, 1, block can accept an operand.
- in_data, input, IN_BITS, operand.
- in_last, input, 1, marks the final beat of a packet (qualified by in_valid).
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, ACC_BITS, accumulated sum modulo 2^ACC_BITS.
- out_count, output, CNT_BITS, number of beats in the packet, saturating.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n low at a clk edge):
  - state <= ACCUM; s, c, result, chunk index, carry bit and count all cleared to 0.
  - out_valid = 0, out_data = 0, out_count = 0.
  - in_ready is forced 0 while rst_n is low.
- States: ACCUM, RESOLVE, DONE; two-bit encoding held in the package.
- ACCUM:
  - in_ready = 1, out_valid = 0.
  - On in_valid&&in_ready, with x = in_data extended per SIGNED_IN:
    - s <= s^x^c;
    - c <= ((s&x)|(s&c)|(x&c)) << 1, MSB dropped (modulo 2^ACC_BITS);
    - count <= count+1, saturating at 2^CNT_BITS-1.
  - If in_last is also set: go to RESOLVE, chunk index k = 0, carry = 0.
  - in_valid low: all state held (bubble).
- RESOLVE:
  - in_ready = 0.
  - Each cycle: {carry, result[k]} <= s[k] + c[k] + carry over CPA_CHUNK bits; k <= k+1.
  - After chunk NCHUNK-1: go to DONE; the final carry-out is discarded.
- DONE:
  - out_valid = 1; out_data = result and out_count = count, both stable until accepted.
  - On out_valid&&out_ready: go to ACCUM and clear s, c, count. out_data keeps its value, don't-care once out_valid = 0.
- Latency: out_valid is first seen NCHUNK cycles after the edge that accepts the last beat. Example: NCHUNK=2 means last beat at edge E0, out_valid high after E2.
- Throughput:
  - 1 operand per cycle inside a packet.
  - Between packets in_ready is low for NCHUNK + 1 + (cycles out_ready is low) cycles.
- Boundary conditions:
  - A single-beat packet (in_last on the first beat) is legal.
  - in_data/in_last are ignored when in_ready = 0.
  - Overflow wraps modulo 2^ACC_BITS; no flag.
  - Reset mid-packet or in RESOLVE/DONE aborts: partial data is discarded and the result is never emitted.
  - out_ready high outside DONE has no effect.

Decomposition:
- Shared package:
  - state encoding (ACCUM=0, RESOLVE=1, DONE=2);
  - constant function computing NCHUNK and index width (clog2 of NCHUNK, minimum 1);
  - elaboration check that ACC_BITS % CPA_CHUNK == 0 and ACC_BITS >= IN_BITS.
- Sub-module csa_3to2: parametrised WIDTH, purely combinational sum = a^b^d, carry = maj << 1. Instantiated once at ACC_BITS.
- FSM, chunked CPA and counter stay in the top level.

Test Plan (IN_BITS=8, ACC_BITS=16, CPA_CHUNK=4, CNT_BITS=8 unless noted):
- SIGNED_IN=1; beats 0x05, 0x07, 0x03(last) back-to-back, out_ready=1 -> out_data=0x000F, out_count=3, out_valid seen exactly 4 cycles after the last-beat edge, single cycle wide.
- SIGNED_IN=1; 0xFF, 0xFF(last) -> out_data=0xFFFE. Same stimulus with SIGNED_IN=0 -> out_data=0x01FE.
- SIGNED_IN=0; 258 beats of 0xFF with random in_valid bubbles -> out_data=0x00FE (wrap), out_count=0xFF (saturated).
- Backpressure: out_ready low 5 cycles in DONE while in_valid=1 is offered -> out_valid, out_data and out_count stable, in_ready=0, no operand consumed. Raise out_ready -> next packet 0x02(last) gives 0x0002, count 1.
- rst_n low for one edge during RESOLVE -> out_valid stays 0 and no result is emitted. Then packet 0x01(last) -> out_data=0x0001, out_count=1.
- Single-beat packet 0x80(last): SIGNED_IN=1 -> 0xFF80; SIGNED_IN=0 -> 0x0080.
